irq_sched_ctrl: RTL and testbench

IRQ_SCHED_CTRL -- requirements
Module: irq_sched_ctrl

---
 rtl/irq_sched_ctrl_pkg.sv | 20 ++
 rtl/irq_sched_ctrl_if.sv | 27 ++
 rtl/irq_sched_ctrl_prio_enc.sv | 43 ++++
 rtl/irq_sched_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_sched_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_sched_ctrl_pkg.sv
// Shared types and defaults for the interrupt scheduler: FSM states, bus codes,
// and the default channel/bus/timeout sizing.
package irq_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_GRANT   = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    localparam int NCH_DEF  = 9;
    localparam int NBUS_DEF = 3;
    localparam int TMO_DEF  = 255;

endpackage

// File: rtl/irq_sched_ctrl_if.sv
// Request/grant bundle between the interrupt sources/consumer (master) and the
// scheduler (slave).
interface irq_sched_ctrl_if #(parameter int NCH = 9);

    logic [NCH-1:0] req_a;
    logic [NCH-1:0] req_b;
    logic [NCH-1:0] req_c;
    logic [NCH-1:0] en;
    logic           irq_ack;
    logic           eoi;
    logic           irq_valid;
    logic [1:0]     irq_bus;
    logic [3:0]     irq_chan;
    logic           busy;
    logic           tmo_err;

    modport master (
        output req_a, req_b, req_c, en, irq_ack, eoi,
        input  irq_valid, irq_bus, irq_chan, busy, tmo_err
    );

    modport slave (
        input  req_a, req_b, req_c, en, irq_ack, eoi,
        output irq_valid, irq_bus, irq_chan, busy, tmo_err
    );

endinterface

// File: rtl/irq_sched_ctrl_prio_enc.sv
// Combinational priority pick: bus A over B over C, lowest channel within a bus.
module irq_prio_enc
    import irq_sched_ctrl_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0] pa,
    input  logic [NCH-1:0] pb,
    input  logic [NCH-1:0] pc,
    output logic           valid,
    output logic [1:0]     bus,
    output logic [3:0]     chan
);

    // Scan lowest priority first so each later hit overrides the earlier one.
    always_comb begin
        valid = 1'b0;
        bus   = BUS_A;
        chan  = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pc[i]) begin
                valid = 1'b1;
                bus   = BUS_C;
                chan  = 4'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pb[i]) begin
                valid = 1'b1;
                bus   = BUS_B;
                chan  = 4'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pa[i]) begin
                valid = 1'b1;
                bus   = BUS_A;
                chan  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sched_ctrl.sv
// Interrupt scheduler: sticky per-bus pending bits, one-cycle arbitration,
// grant/ack handshake and a service timer with timeout reporting.
module irq_sched_ctrl
    import irq_sched_ctrl_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int NBUS = NBUS_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    irq_sched_ctrl_if.slave   bus
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_V = TW'(TMO);

    state_t          state;
    logic [NCH-1:0]  pend   [NBUS];
    logic [NCH-1:0]  req_in [NBUS];
    logic [NCH-1:0]  elig   [NBUS];
    logic [NCH-1:0]  clr    [NBUS];
    logic [TW-1:0]   timer;
    logic            valid_q;
    logic [1:0]      bus_q;
    logic [3:0]      chan_q;
    logic            busy_q;
    logic            tmo_q;
    logic            win_valid;
    logic [1:0]      win_bus;
    logic [3:0]      win_chan;
    logic            ack_clr;

    assign ack_clr = (state == S_GRANT) && bus.irq_ack;

    for (genvar b = 0; b < NBUS; b++) begin : g_bus
        assign req_in[b] = (b == int'(BUS_A)) ? bus.req_a :
                           (b == int'(BUS_B)) ? bus.req_b :
                           (b == int'(BUS_C)) ? bus.req_c : '0;
        assign elig[b]   = pend[b] & bus.en;
        assign clr[b]    = (ack_clr && bus_q == 2'(b)) ?
                           ({{(NCH-1){1'b0}}, 1'b1} << chan_q) : '0;
    end

    irq_prio_enc #(.NCH(NCH)) u_prio (
        .pa    (elig[BUS_A]),
        .pb    (elig[BUS_B]),
        .pc    (elig[BUS_C]),
        .valid (win_valid),
        .bus   (win_bus),
        .chan  (win_chan)
    );

    // Clear applies before the OR so a same-cycle request re-arms the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBUS; b++) pend[b] <= '0;
        end else begin
            for (int b = 0; b < NBUS; b++) pend[b] <= (pend[b] & ~clr[b]) | req_in[b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            valid_q <= 1'b0;
            bus_q   <= 2'd0;
            chan_q  <= 4'd0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        state  <= S_ARB;
                        busy_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (win_valid) begin
                        bus_q   <= win_bus;
                        chan_q  <= win_chan;
                        valid_q <= 1'b1;
                        state   <= S_GRANT;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (bus.irq_ack) begin
                        valid_q <= 1'b0;
                        timer   <= '0;
                        state   <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    // eoi is checked first so it beats a timeout in the same cycle.
                    if (bus.eoi) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (timer == TMO_V) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        tmo_q  <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_bus   = bus_q;
    assign bus.irq_chan  = chan_q;
    assign bus.busy      = busy_q;
    assign bus.tmo_err   = tmo_q;

endmodule

// File: tb/tb_irq_sched_ctrl.sv
// Directed bench for irq_sched_ctrl: expected grants are queued when requests
// are driven and popped when the DUT presents irq_valid.
module tb_irq_sched_ctrl;
    import irq_sched_ctrl_pkg::*;

    localparam int NCH = 9;
    localparam int TMO = 255;

    typedef struct packed {
        logic [1:0] b;
        logic [3:0] c;
    } grant_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    grant_t sb[$];

    irq_sched_ctrl_if #(.NCH(NCH)) dif ();

    irq_sched_ctrl #(.NCH(NCH), .NBUS(3), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] a, input logic [NCH-1:0] b,
                                 input logic [NCH-1:0] c);
        dif.req_a = a;
        dif.req_b = b;
        dif.req_c = c;
        tick();
        dif.req_a = '0;
        dif.req_b = '0;
        dif.req_c = '0;
    endtask

    task automatic expectGrant(input logic [1:0] b, input int c);
        grant_t g;
        g.b = b;
        g.c = 4'(c);
        sb.push_back(g);
    endtask

    task automatic waitGrant(input string tag);
        grant_t g;
        int n;
        n = 0;
        while (dif.irq_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(dif.irq_valid), 32'd1);
        checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (dif.irq_valid === 1'b1 && sb.size() > 0) begin
            g = sb.pop_front();
            checkOutput({tag, "_bus"}, 32'(dif.irq_bus), 32'(g.b));
            checkOutput({tag, "_chan"}, 32'(dif.irq_chan), 32'(g.c));
        end
    endtask

    task automatic ackEoi(input string tag);
        dif.irq_ack = 1'b1;
        tick();
        dif.irq_ack = 1'b0;
        checkOutput({tag, "_svc_valid"}, 32'(dif.irq_valid), 32'd0);
        checkOutput({tag, "_svc_busy"}, 32'(dif.busy), 32'd1);
        dif.eoi = 1'b1;
        tick();
        dif.eoi = 1'b0;
        checkOutput({tag, "_eoi_busy"}, 32'(dif.busy), 32'd0);
    endtask

    initial begin
        int seen;
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        dif.req_a   = '0;
        dif.req_b   = '0;
        dif.req_c   = '0;
        dif.en      = '1;
        dif.irq_ack = 1'b0;
        dif.eoi     = 1'b0;

        tick();
        tick();
        checkOutput("rst_valid", 32'(dif.irq_valid), 32'd0);
        checkOutput("rst_busy", 32'(dif.busy), 32'd0);
        checkOutput("rst_bus", 32'(dif.irq_bus), 32'd0);
        checkOutput("rst_chan", 32'(dif.irq_chan), 32'd0);
        checkOutput("rst_tmo", 32'(dif.tmo_err), 32'd0);
        rst = 1'b0;

        $display("[TB] single request latency");
        expectGrant(BUS_A, 4);
        applyStimulus(9'h010, '0, '0);
        checkOutput("lat_e0_valid", 32'(dif.irq_valid), 32'd0);
        checkOutput("lat_e0_busy", 32'(dif.busy), 32'd0);
        tick();
        checkOutput("lat_e1_valid", 32'(dif.irq_valid), 32'd0);
        checkOutput("lat_e1_busy", 32'(dif.busy), 32'd1);
        tick();
        checkOutput("lat_e2_valid", 32'(dif.irq_valid), 32'd1);
        waitGrant("a4");
        ackEoi("a4");

        $display("[TB] cross-bus priority");
        expectGrant(BUS_A, 7);
        expectGrant(BUS_B, 2);
        expectGrant(BUS_C, 0);
        applyStimulus(9'h080, 9'h004, 9'h001);
        waitGrant("a7");
        ackEoi("a7");
        waitGrant("b2");
        ackEoi("b2");
        waitGrant("c0");
        ackEoi("c0");

        $display("[TB] in-bus priority");
        expectGrant(BUS_B, 3);
        expectGrant(BUS_B, 6);
        applyStimulus('0, 9'h048, '0);
        waitGrant("b3");
        ackEoi("b3");
        waitGrant("b6");
        ackEoi("b6");

        $display("[TB] disabled channel");
        dif.en = 9'h1FD;
        applyStimulus(9'h002, '0, '0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("dis_valid", 32'(dif.irq_valid), 32'd0);
        checkOutput("dis_busy", 32'(dif.busy), 32'd0);
        dif.en = '1;
        expectGrant(BUS_A, 1);
        waitGrant("a1");
        ackEoi("a1");

        $display("[TB] stalled grant and re-request on ack");
        expectGrant(BUS_A, 3);
        applyStimulus(9'h008, '0, '0);
        waitGrant("a3");
        dif.en = '0;
        for (int i = 0; i < 20; i++) begin
            dif.eoi = (i == 5);
            tick();
            checkOutput("stall_valid", 32'(dif.irq_valid), 32'd1);
            checkOutput("stall_bus", 32'(dif.irq_bus), 32'(BUS_A));
            checkOutput("stall_chan", 32'(dif.irq_chan), 32'd3);
        end
        dif.eoi = 1'b0;
        dif.en = '1;
        dif.req_a = 9'h008;
        dif.irq_ack = 1'b1;
        tick();
        dif.req_a = '0;
        dif.irq_ack = 1'b0;
        checkOutput("reack_valid", 32'(dif.irq_valid), 32'd0);
        expectGrant(BUS_A, 3);
        dif.eoi = 1'b1;
        tick();
        dif.eoi = 1'b0;
        waitGrant("a3_again");
        ackEoi("a3_again");
        for (int i = 0; i < 5; i++) tick();
        checkOutput("cleared_busy", 32'(dif.busy), 32'd0);

        $display("[TB] service timeout");
        expectGrant(BUS_C, 8);
        applyStimulus('0, '0, 9'h100);
        waitGrant("c8");
        dif.irq_ack = 1'b1;
        tick();
        dif.irq_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (dif.tmo_err !== 1'b0) seen++;
        end
        checkOutput("tmo_early", 32'(seen), 32'd0);
        checkOutput("tmo_busy_pre", 32'(dif.busy), 32'd1);
        tick();
        checkOutput("tmo_pulse", 32'(dif.tmo_err), 32'd1);
        checkOutput("tmo_busy_post", 32'(dif.busy), 32'd0);
        tick();
        checkOutput("tmo_one_cycle", 32'(dif.tmo_err), 32'd0);

        $display("[TB] eoi in the timeout cycle");
        expectGrant(BUS_B, 0);
        applyStimulus('0, 9'h001, '0);
        waitGrant("b0");
        dif.irq_ack = 1'b1;
        tick();
        dif.irq_ack = 1'b0;
        for (int i = 0; i < TMO; i++) tick();
        dif.eoi = 1'b1;
        tick();
        dif.eoi = 1'b0;
        checkOutput("eoi_wins_tmo", 32'(dif.tmo_err), 32'd0);
        checkOutput("eoi_wins_busy", 32'(dif.busy), 32'd0);
        tick();
        checkOutput("eoi_wins_tmo2", 32'(dif.tmo_err), 32'd0);

        $display("[TB] reset during service");
        expectGrant(BUS_A, 6);
        applyStimulus(9'h040, '0, '0);
        waitGrant("a6");
        dif.irq_ack = 1'b1;
        tick();
        dif.irq_ack = 1'b0;
        applyStimulus('0, 9'h002, 9'h004);
        tick();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(dif.irq_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(dif.busy), 32'd0);
        checkOutput("mid_rst_chan", 32'(dif.irq_chan), 32'd0);
        checkOutput("mid_rst_bus", 32'(dif.irq_bus), 32'd0);
        checkOutput("mid_rst_tmo", 32'(dif.tmo_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dif.busy !== 1'b0 || dif.irq_valid !== 1'b0 || dif.tmo_err !== 1'b0) seen++;
        end
        checkOutput("post_rst_quiet", 32'(seen), 32'd0);

        $display("[TB] first request after reset");
        expectGrant(BUS_A, 0);
        applyStimulus(9'h001, '0, '0);
        tick();
        tick();
        checkOutput("post_rst_lat", 32'(dif.irq_valid), 32'd1);
        waitGrant("a0");
        ackEoi("a0");
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
